// File: rtl/operand_arbiter_pkg.sv
// rtl/operand_arbiter_pkg.sv - shared state encoding and source ids for the operand arbiter
package operand_arbiter_pkg;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Requester ids, as seen on out_src and mux_sel
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/operand_arbiter_if.sv
// rtl/operand_arbiter_if.sv - requester, output and status signals of the operand arbiter
interface operand_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);

  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             ack_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             ack_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             mux_sel;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  // Arbiter side
  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output ack_a, ack_b, out_valid, out_data, out_src, mux_sel, cnt_a, cnt_b
  );

  // Requesters and consumer side
  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  ack_a, ack_b, out_valid, out_data, out_src, mux_sel, cnt_a, cnt_b
  );

endinterface

// File: rtl/operand_arbiter_mux.sv
// rtl/operand_arbiter_mux.sv - 2:1 operand select shared by both requesters
module Mux32Bit2To1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/operand_arbiter.sv
// rtl/operand_arbiter.sv - round-robin arbiter of two operand sources into one output register
module operand_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  operand_arbiter_if.slave  bus
);

  import operand_arbiter_pkg::*;

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic             mux_sel_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  logic             can_accept;
  logic             grant_valid;
  logic             grant_src;
  logic             mux_sel;
  logic [WIDTH-1:0] mux_out;

  // Grant decision and next occupancy; reset suppresses any grant so no ack is seen
  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_src   = SRC_A;
    can_accept  = (state_q == ST_EMPTY) || bus.out_ready;
    if (!rst && can_accept && (bus.req_a || bus.req_b)) begin
      grant_valid = 1'b1;
      if (bus.req_a && bus.req_b) begin
        grant_src = ~last_grant_q;
      end else begin
        grant_src = bus.req_b ? SRC_B : SRC_A;
      end
    end
    case (state_q)
      ST_EMPTY: if (grant_valid) state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready && !grant_valid) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Select follows the live grant and otherwise keeps pointing at the last winner
  always_comb begin
    mux_sel = grant_valid ? grant_src : mux_sel_q;
  end

  Mux32Bit2To1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .in0_i (bus.data_a),
    .in1_i (bus.data_b),
    .sel_i (mux_sel),
    .out_o (mux_out)
  );

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Output register, arbitration history and held select; last_grant resets to B so A wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_src_q    <= SRC_A;
      last_grant_q <= SRC_B;
      mux_sel_q    <= SRC_A;
    end else if (grant_valid) begin
      out_data_q   <= mux_out;
      out_src_q    <= grant_src;
      last_grant_q <= grant_src;
      mux_sel_q    <= grant_src;
    end
  end

  // Per-source accepted-operand counters, sticking at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (grant_valid) begin
      if (grant_src == SRC_A && cnt_a_q != {CNT_W{1'b1}}) cnt_a_q <= cnt_a_q + CNT_W'(1);
      if (grant_src == SRC_B && cnt_b_q != {CNT_W{1'b1}}) cnt_b_q <= cnt_b_q + CNT_W'(1);
    end
  end

  assign bus.ack_a     = grant_valid && (grant_src == SRC_A);
  assign bus.ack_b     = grant_valid && (grant_src == SRC_B);
  assign bus.mux_sel   = mux_sel;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.cnt_a     = cnt_a_q;
  assign bus.cnt_b     = cnt_b_q;

endmodule
